alu_seq: RTL

Parametrised, clocked successor of the team's 4-bit combinational ALU.
- Keeps the same opcode map for single-cycle ops (ADD..SHR).
- Adds multi-cycle MUL (shift-add) and DIV (restoring) with a start/busy/done handshake.
- Outputs are registered.
- Sits between the register file and the writeback mux of the parametrised CPU datapath.

---
 rtl/alu_seq.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle logic/arith ops, multi-cycle shift-add MUL and restoring DIV.
// Optional divider datapath enabled by defining ALU_DIV_EN; otherwise opcode 0010 is illegal.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             zero_flag,
  output logic             negative_flag,
  output logic             carry_flag,
  output logic             overflow_flag
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  typedef enum logic [3:0] {
    OP_MUL = 4'b0001,
    OP_DIV = 4'b0010,
    OP_ADD = 4'b1000,
    OP_SUB = 4'b1001,
    OP_AND = 4'b1010,
    OP_OR  = 4'b1011,
    OP_XOR = 4'b1100,
    OP_NOT = 4'b1101,
    OP_SHL = 4'b1110,
    OP_SHR = 4'b1111
  } op_e;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state, state_next;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic [CW-1:0]    count;
  logic             multi_op, load_op, load_sc, load_mc;

  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v;
  logic [WIDTH:0]   wide;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] it_hi, it_lo;
  logic             mc_c, mc_v;

  logic [WIDTH-1:0] nx_res, nx_rem;
  logic             nx_c, nx_v;

`ifdef ALU_DIV_EN
  logic             op_mul;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  assign multi_op = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, opnd};
  assign div_diff = div_sh[WIDTH-1:0] - opnd;
`else
  assign multi_op = (opcode == OP_MUL);
`endif

  assign busy = (state == EXEC);
  assign done = (state == DONE);

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    wide   = '0;
    case (opcode)
      OP_ADD: begin
        wide   = {1'b0, A} + {1'b0, B};
        sc_res = wide[WIDTH-1:0];
        sc_c   = wide[WIDTH];
        sc_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sc_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        wide   = {1'b0, A} - {1'b0, B};
        sc_res = wide[WIDTH-1:0];
        sc_c   = wide[WIDTH];
        sc_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sc_res[WIDTH-1] == B[WIDTH-1]);
      end
      OP_AND: sc_res = A & B;
      OP_OR:  sc_res = A | B;
      OP_XOR: sc_res = A ^ B;
      OP_NOT: sc_res = ~A;
      OP_SHL: begin
        sc_res = {A[WIDTH-2:0], 1'b0};
        sc_c   = A[WIDTH-1];
      end
      OP_SHR: begin
        sc_res = {1'b0, A[WIDTH-1:1]};
        sc_c   = A[0];
      end
      default: ;
    endcase
  end

  // acc_hi:acc_lo is the product (MUL) or remainder:quotient (DIV) shift pair
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

  always_comb begin
    it_hi = mul_sum[WIDTH:1];
    it_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    mc_c  = |it_hi;
    mc_v  = 1'b0;
`ifdef ALU_DIV_EN
    // B == 0 always "fits": quotient fills with ones and A shifts through into the remainder
    if (!op_mul) begin
      it_hi = div_ge ? div_diff : div_sh[WIDTH-1:0];
      it_lo = {acc_lo[WIDTH-2:0], div_ge};
      mc_c  = 1'b0;
      mc_v  = (opnd == '0);
    end
`endif
  end

  always_comb begin
    nx_res = sc_res;
    nx_rem = '0;
    nx_c   = sc_c;
    nx_v   = sc_v;
    if (state == EXEC) begin
      nx_res = it_lo;
      nx_rem = it_hi;
      nx_c   = mc_c;
      nx_v   = mc_v;
    end
  end

  always_comb begin
    state_next = state;
    load_op    = 1'b0;
    load_sc    = 1'b0;
    load_mc    = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          if (multi_op) begin
            state_next = EXEC;
            load_op    = 1'b1;
          end else begin
            state_next = DONE;
            load_sc    = 1'b1;
          end
        end
      end
      EXEC: begin
        if (count == LAST) begin
          state_next = DONE;
          load_mc    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      count  <= '0;
`ifdef ALU_DIV_EN
      op_mul <= 1'b0;
`endif
    end else if (load_op) begin
      acc_hi <= '0;
      count  <= '0;
`ifdef ALU_DIV_EN
      op_mul <= (opcode == OP_MUL);
      if (opcode == OP_MUL) begin
        acc_lo <= B;
        opnd   <= A;
      end else begin
        acc_lo <= A;
        opnd   <= B;
      end
`else
      acc_lo <= B;
      opnd   <= A;
`endif
    end else if (state == EXEC) begin
      acc_hi <= it_hi;
      acc_lo <= it_lo;
      count  <= count + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result        <= '0;
      remainder     <= '0;
      zero_flag     <= 1'b0;
      negative_flag <= 1'b0;
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
    end else if (load_sc || load_mc) begin
      result        <= nx_res;
      remainder     <= nx_rem;
      zero_flag     <= (nx_res == '0);
      negative_flag <= nx_res[WIDTH-1];
      carry_flag    <= nx_c;
      overflow_flag <= nx_v;
    end
  end

endmodule
